// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of pc_sequencer: redirect requests in, program counter and status out.
`default_nettype none

interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             trg_i;
  logic             stall_i;
  logic             halt_i;
  logic             branch_taken_i;
  logic [WIDTH-1:0] branch_target_i;
  logic             jalr_i;
  logic [WIDTH-1:0] jalr_target_i;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_next_o;
  logic             fetch_valid_o;
  logic             flush_o;
  logic             misalign_o;
  logic             halted_o;
  logic [7:0]       redirect_cnt_o;

  modport master (
    output trg_i, stall_i, halt_i, branch_taken_i, branch_target_i, jalr_i, jalr_target_i,
    input  pc_o, pc_next_o, fetch_valid_o, flush_o, misalign_o, halted_o, redirect_cnt_o
  );

  modport slave (
    input  trg_i, stall_i, halt_i, branch_taken_i, branch_target_i, jalr_i, jalr_target_i,
    output pc_o, pc_next_o, fetch_valid_o, flush_o, misalign_o, halted_o, redirect_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter; arbitrates trap, jump, branch, halt and stall,
// and holds a fixed number of flush bubbles after every redirect.
`default_nettype none

module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VEC    = 32'h0,
  parameter logic [WIDTH-1:0] TRAP_VEC     = 32'h5,
  parameter int               FLUSH_CYCLES = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [3:0]       bub_q, bub_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic             valid_q, flush_q, mis_q, halted_q;
  logic             mis_d;
  logic             redirect;

  logic [WIDTH-1:0] jalr_tgt;
  logic [WIDTH-1:0] redir_tgt;
  logic             redir_bad;

  assign jalr_tgt  = bus.jalr_target_i & ~{{(WIDTH-1){1'b0}}, 1'b1};
  assign redir_tgt = bus.jalr_i ? jalr_tgt : bus.branch_target_i;
  assign redir_bad = |redir_tgt[1:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bub_d    = bub_q;
    rcnt_d   = rcnt_q;
    mis_d    = 1'b0;
    redirect = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (bus.trg_i) begin
          pc_d     = TRAP_VEC;
          redirect = 1'b1;
        end else if (bus.jalr_i || bus.branch_taken_i) begin
          redirect = 1'b1;
          if (redir_bad) begin
            pc_d  = TRAP_VEC;
            mis_d = 1'b1;
          end else begin
            pc_d = redir_tgt;
          end
        end else if (bus.halt_i) begin
          state_d = S_HALT;
        end else if (!bus.stall_i) begin
          pc_d = pc_q + WIDTH'(4);
        end
      end
      S_FLUSH: begin
        // Wrong-path branch/jump/halt are dropped; only a trigger restarts the bubble.
        if (bus.trg_i) begin
          pc_d     = TRAP_VEC;
          redirect = 1'b1;
        end else if (!bus.stall_i) begin
          if (bub_q <= 4'd1) state_d = S_RUN;
          else               bub_d   = bub_q - 4'd1;
        end
      end
      S_HALT: begin
        if (bus.trg_i) begin
          pc_d     = TRAP_VEC;
          redirect = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) begin
      state_d = S_FLUSH;
      bub_d   = 4'(FLUSH_CYCLES);
      if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VEC;
      bub_q    <= 4'd0;
      rcnt_q   <= 8'd0;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      mis_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bub_q    <= bub_d;
      rcnt_q   <= rcnt_d;
      valid_q  <= (state_d == S_RUN);
      flush_q  <= (state_d == S_FLUSH);
      mis_q    <= mis_d;
      halted_q <= (state_d == S_HALT);
    end
  end

  assign bus.pc_o           = pc_q;
  assign bus.pc_next_o      = rst ? RESET_VEC : pc_d;
  assign bus.fetch_valid_o  = valid_q;
  assign bus.flush_o        = flush_q;
  assign bus.misalign_o     = mis_q;
  assign bus.halted_o       = halted_q;
  assign bus.redirect_cnt_o = rcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (WIDTH=32, RESET_VEC=0, TRAP_VEC=5, FLUSH_CYCLES=2).
`default_nettype none

module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h5), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic clr_in();
    bus.trg_i = 0; bus.stall_i = 0; bus.halt_i = 0;
    bus.branch_taken_i = 0; bus.branch_target_i = '0;
    bus.jalr_i = 0; bus.jalr_target_i = '0;
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    clr_in();
    rst = 1'b1;
    tick();
    nvec++;
    if (bus.pc_o !== 32'h0 || bus.fetch_valid_o !== 1'b0 || bus.flush_o !== 1'b0 ||
        bus.misalign_o !== 1'b0 || bus.halted_o !== 1'b0 || bus.redirect_cnt_o !== 8'd0) begin
      nerr++;
      $display("FAIL reset_vals: pc=%h v=%b f=%b m=%b h=%b cnt=%0d, required pc=0 rest 0",
               bus.pc_o, bus.fetch_valid_o, bus.flush_o, bus.misalign_o, bus.halted_o, bus.redirect_cnt_o);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (bus.pc_o !== 32'h0 || bus.pc_next_o !== 32'h0 || bus.fetch_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL idle: pc=%h next=%h valid=%b, required 0/0/0", bus.pc_o, bus.pc_next_o, bus.fetch_valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++;
      if (bus.pc_o !== exp_pc[i] || bus.fetch_valid_o !== 1'b1) begin
        nerr++;
        $display("FAIL seq_%0d: pc=%h valid=%b, required pc=%h valid=1", i, bus.pc_o, bus.fetch_valid_o, exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick();
    bus.branch_taken_i = 1; bus.branch_target_i = 32'h40;
    #1;
    nvec++;
    if (bus.pc_o !== 32'h8 || bus.pc_next_o !== 32'h40) begin
      nerr++;
      $display("FAIL br_next: pc=%h next=%h, required 8/40", bus.pc_o, bus.pc_next_o);
    end
    tick();
    clr_in();
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (bus.pc_o !== 32'h40 || bus.flush_o !== 1'b1 || bus.fetch_valid_o !== 1'b0) begin
        nerr++;
        $display("FAIL br_flush_%0d: pc=%h f=%b v=%b, required 40/1/0", i, bus.pc_o, bus.flush_o, bus.fetch_valid_o);
      end
      tick();
    end
    nvec++;
    if (bus.pc_o !== 32'h40 || bus.flush_o !== 1'b0 || bus.fetch_valid_o !== 1'b1 || bus.redirect_cnt_o !== 8'd1) begin
      nerr++;
      $display("FAIL br_resume: pc=%h f=%b v=%b cnt=%0d, required 40/0/1/1",
               bus.pc_o, bus.flush_o, bus.fetch_valid_o, bus.redirect_cnt_o);
    end
    tick();
    nvec++;
    if (bus.pc_o !== 32'h44) begin
      nerr++;
      $display("FAIL br_inc: pc=%h, required 44", bus.pc_o);
    end
  endtask

  task automatic test_jalr();
    bus.jalr_i = 1; bus.jalr_target_i = 32'h101;
    tick();
    clr_in();
    nvec++;
    if (bus.pc_o !== 32'h100 || bus.misalign_o !== 1'b0 || bus.redirect_cnt_o !== 8'd2) begin
      nerr++;
      $display("FAIL jalr_101: pc=%h mis=%b cnt=%0d, required 100/0/2", bus.pc_o, bus.misalign_o, bus.redirect_cnt_o);
    end
    // Wrong-path branch and halt during FLUSH must be dropped.
    bus.branch_taken_i = 1; bus.branch_target_i = 32'h200; bus.halt_i = 1;
    tick(); tick();
    clr_in();
    nvec++;
    if (bus.pc_o !== 32'h100 || bus.fetch_valid_o !== 1'b1 || bus.redirect_cnt_o !== 8'd2 || bus.halted_o !== 1'b0) begin
      nerr++;
      $display("FAIL flush_ignore: pc=%h v=%b cnt=%0d h=%b, required 100/1/2/0",
               bus.pc_o, bus.fetch_valid_o, bus.redirect_cnt_o, bus.halted_o);
    end
    bus.jalr_i = 1; bus.jalr_target_i = 32'h102;
    tick();
    clr_in();
    nvec++;
    if (bus.pc_o !== 32'h5 || bus.misalign_o !== 1'b1 || bus.redirect_cnt_o !== 8'd3 || bus.flush_o !== 1'b1) begin
      nerr++;
      $display("FAIL jalr_102: pc=%h mis=%b cnt=%0d f=%b, required 5/1/3/1",
               bus.pc_o, bus.misalign_o, bus.redirect_cnt_o, bus.flush_o);
    end
    tick();
    nvec++;
    if (bus.misalign_o !== 1'b0 || bus.pc_o !== 32'h5) begin
      nerr++;
      $display("FAIL mis_pulse: mis=%b pc=%h, required 0/5", bus.misalign_o, bus.pc_o);
    end
    tick();
  endtask

  task automatic test_stall_branch();
    do_reset();
    bus.stall_i = 1; bus.branch_taken_i = 1; bus.branch_target_i = 32'h80;
    #1;
    nvec++;
    if (bus.pc_next_o !== 32'h80) begin
      nerr++;
      $display("FAIL stall_br_next: next=%h, required 80", bus.pc_next_o);
    end
    tick();
    clr_in();
    for (int i = 0; i < 5; i++) begin
      bus.stall_i = (i <= 2);
      nvec++;
      if (bus.pc_o !== 32'h80 || bus.flush_o !== 1'b1 || bus.fetch_valid_o !== 1'b0) begin
        nerr++;
        $display("FAIL stall_flush_%0d: pc=%h f=%b v=%b, required 80/1/0", i, bus.pc_o, bus.flush_o, bus.fetch_valid_o);
      end
      tick();
    end
    clr_in();
    nvec++;
    if (bus.flush_o !== 1'b0 || bus.fetch_valid_o !== 1'b1 || bus.pc_o !== 32'h80) begin
      nerr++;
      $display("FAIL stall_flush_end: f=%b v=%b pc=%h, required 0/1/80", bus.flush_o, bus.fetch_valid_o, bus.pc_o);
    end
    bus.stall_i = 1;
    tick();
    nvec++;
    if (bus.pc_o !== 32'h80 || bus.fetch_valid_o !== 1'b1) begin
      nerr++;
      $display("FAIL run_stall: pc=%h v=%b, required 80/1", bus.pc_o, bus.fetch_valid_o);
    end
    clr_in();
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    bus.halt_i = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.branch_taken_i = 1; bus.branch_target_i = 32'h40;
      bus.jalr_i = i[0]; bus.jalr_target_i = 32'h300;
      nvec++;
      if (bus.pc_o !== 32'h20 || bus.halted_o !== 1'b1 || bus.fetch_valid_o !== 1'b0) begin
        nerr++;
        $display("FAIL halt_%0d: pc=%h h=%b v=%b, required 20/1/0", i, bus.pc_o, bus.halted_o, bus.fetch_valid_o);
      end
      tick();
    end
    bus.trg_i = 1;
    tick();
    clr_in();
    nvec++;
    if (bus.pc_o !== 32'h5 || bus.halted_o !== 1'b0 || bus.flush_o !== 1'b1 || bus.redirect_cnt_o !== 8'd1) begin
      nerr++;
      $display("FAIL halt_trg: pc=%h h=%b f=%b cnt=%0d, required 5/0/1/1",
               bus.pc_o, bus.halted_o, bus.flush_o, bus.redirect_cnt_o);
    end
    // Trigger on the last bubble restarts the full flush.
    tick();
    bus.trg_i = 1;
    tick();
    clr_in();
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (bus.flush_o !== 1'b1 || bus.pc_o !== 32'h5 || bus.redirect_cnt_o !== 8'd2) begin
        nerr++;
        $display("FAIL trg_restart_%0d: f=%b pc=%h cnt=%0d, required 1/5/2", i, bus.flush_o, bus.pc_o, bus.redirect_cnt_o);
      end
      tick();
    end
    nvec++;
    if (bus.fetch_valid_o !== 1'b1) begin
      nerr++;
      $display("FAIL trg_restart_end: v=%b, required 1", bus.fetch_valid_o);
    end
  endtask

  task automatic test_priority_wrap();
    do_reset();
    bus.jalr_i = 1; bus.jalr_target_i = 32'h300; bus.branch_taken_i = 1; bus.branch_target_i = 32'h400;
    #1;
    nvec++;
    if (bus.pc_next_o !== 32'h300) begin
      nerr++;
      $display("FAIL jalr_over_br: next=%h, required 300", bus.pc_next_o);
    end
    bus.trg_i = 1;
    #1;
    nvec++;
    if (bus.pc_next_o !== 32'h5) begin
      nerr++;
      $display("FAIL trg_over_all: next=%h, required 5", bus.pc_next_o);
    end
    clr_in();
    bus.jalr_i = 1; bus.jalr_target_i = 32'hFFFF_FFFC;
    tick();
    clr_in();
    tick(); tick();
    nvec++;
    if (bus.pc_o !== 32'hFFFF_FFFC || bus.fetch_valid_o !== 1'b1) begin
      nerr++;
      $display("FAIL wrap_pre: pc=%h v=%b, required fffffffc/1", bus.pc_o, bus.fetch_valid_o);
    end
    tick();
    nvec++;
    if (bus.pc_o !== 32'h0) begin
      nerr++;
      $display("FAIL wrap: pc=%h, required 0", bus.pc_o);
    end
  endtask

  task automatic test_saturate_async();
    do_reset();
    bus.trg_i = 1;
    for (int i = 0; i < 255; i++) tick();
    nvec++;
    if (bus.redirect_cnt_o !== 8'd255) begin
      nerr++;
      $display("FAIL cnt_255: cnt=%0d, required 255", bus.redirect_cnt_o);
    end
    tick();
    nvec++;
    if (bus.redirect_cnt_o !== 8'd255 || bus.flush_o !== 1'b1) begin
      nerr++;
      $display("FAIL cnt_sat: cnt=%0d f=%b, required 255/1", bus.redirect_cnt_o, bus.flush_o);
    end
    clr_in();
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (bus.pc_o !== 32'h0 || bus.flush_o !== 1'b0 || bus.redirect_cnt_o !== 8'd0 || bus.fetch_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL async_rst: pc=%h f=%b cnt=%0d v=%b, required 0/0/0/0",
               bus.pc_o, bus.flush_o, bus.redirect_cnt_o, bus.fetch_valid_o);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_stall_branch();
    test_halt();
    test_priority_wrap();
    test_saturate_async();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that owns the architectural program counter and decides its next value every cycle.
- Arbitrates between sequential fetch, stall, branch, JALR, halt and an external trigger/trap vector.
- Inserts a fixed number of flush bubbles after any redirect.
- Sits between the fetch stage and the execute-stage branch/jump resolution logic in the single-cycle/pipelined RISC-V core.

Parameters:
- WIDTH, 32, PC/address width.
- RESET_VEC, 32'h0, PC value after reset.
- TRAP_VEC, 32'h5, PC loaded on trigger or misaligned-target trap.
- FLUSH_CYCLES, 2, bubble cycles after a redirect (legal range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- trg_i  input  1  trigger request; highest priority redirect to TRAP_VEC.
- stall_i  input  1  hold PC (hazard stall).
- halt_i  input  1  stop fetching until trigger or reset.
- branch_taken_i  input  1  resolved conditional branch taken.
- branch_target_i  input  WIDTH  branch target address.
- jalr_i  input  1  JALR/JAL redirect.
- jalr_target_i  input  WIDTH  jump target; bit 0 is cleared before use.
- pc_o  output  WIDTH  current PC (registered).
- pc_next_o  output  WIDTH  value pc_o takes at next edge (combinational).
- fetch_valid_o  output  1  fetch at pc_o is architecturally valid.
- flush_o  output  1  kill younger pipeline contents (registered).
- misalign_o  output  1  one-cycle pulse: redirect target had bits[1:0] != 0.
- halted_o  output  1  high in HALT.
- redirect_cnt_o  output  8  count of accepted redirects, saturating at 255.

Behaviour:
- States: IDLE, RUN, FLUSH, HALT.
- Reset (async, immediate) values:
  - pc_o=RESET_VEC, state=IDLE, counter=0.
  - fetch_valid_o=0, flush_o=0, misalign_o=0, halted_o=0, redirect_cnt_o=0.
- IDLE: one cycle, pc held. Goes to RUN; fetch_valid_o=1 from the first RUN cycle.
- RUN priority, highest first:
  - trg_i: pc<=TRAP_VEC; redirect; go to FLUSH.
  - jalr_i: target = jalr_target_i & ~1.
  - branch_taken_i: target = branch_target_i.
  - halt_i: pc held; go to HALT; fetch_valid_o=0.
  - stall_i: pc held; fetch_valid_o stays 1.
  - otherwise: pc<=pc+4, modulo 2^WIDTH (0xFFFFFFFC wraps to 0x0).
- Redirect target check (jalr/branch):
  - If target[1:0]!=0: pc<=TRAP_VEC and misalign_o pulses next cycle.
  - Else pc<=target.
  - TRAP_VEC itself is exempt from the alignment check.
- Every accepted redirect (trigger, jump, branch or misalign trap):
  - Increments redirect_cnt_o (saturating at 255).
  - Loads bubble counter with FLUSH_CYCLES.
  - Enters FLUSH.
- FLUSH:
  - flush_o=1, fetch_valid_o=0, pc held at redirect value.
  - Counter decrements each cycle stall_i=0 and freezes while stall_i=1.
  - On the cycle the counter reaches 1 with no stall, next state is RUN.
  - Duration is exactly FLUSH_CYCLES cycles absent stalls.
  - branch_taken_i, jalr_i and halt_i are ignored (wrong-path).
  - trg_i restarts FLUSH with pc<=TRAP_VEC and counts as a redirect.
- HALT:
  - pc held, halted_o=1, fetch_valid_o=0; all inputs ignored except trg_i.
  - trg_i redirects to TRAP_VEC via FLUSH; halted_o drops the next cycle.
- Simultaneous events:
  - branch + stall: branch wins.
  - jalr + branch: jalr wins.
  - trg_i + any other input: trg_i wins.
- pc_next_o always equals the value pc_o will load, including during reset release (RESET_VEC in IDLE).
- Reset asserted mid-FLUSH or mid-HALT clears all state immediately, without waiting for a clock edge.

Test Plan:
- Reset release, no inputs: pc_o sequence 0x0 (IDLE), 0x0, 0x4, 0x8, 0xC; fetch_valid_o 0 then 1.
- Branch at pc=0x8 with target 0x40 (FLUSH_CYCLES=2): pc_o=0x40 for 2 cycles; flush_o=1 and fetch_valid_o=0 for 2 cycles; then 0x40 valid, 0x44; redirect_cnt_o=1.
- JALR to 0x101: pc_o=0x100 with no misalign. JALR to 0x102: misalign_o pulses once and pc_o=0x5.
- Same cycle stall_i=1 + branch_taken_i=1 (target 0x80): pc_o=0x80 next. Then stall during FLUSH for 3 cycles: FLUSH lasts 5 cycles total.
- halt_i at pc=0x20: pc stays 0x20 and halted_o=1 for 10 cycles despite branches. Then trg_i: pc_o=0x5, halted_o=0, FLUSH entered.
- 256 redirects: redirect_cnt_o saturates at 255. Async rst mid-FLUSH: pc_o=0x0, flush_o=0 and redirect_cnt_o=0 before the next clock edge.
